// File: rtl/zigzag_rle_encoder.sv
// Reads a finished 8x8 quantised block in zigzag order and emits JPEG-style
// run-length symbols (DC, run/level, ZRL, EOB) to the entropy coder.
module zigzag_rle_encoder #(
  parameter int COEF_W = 12
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     hold,
  input  logic                     dctq_valid,
  output logic                     rd_en,
  output logic [5:0]               rd_addr,
  input  logic signed [COEF_W-1:0] coef_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_dc,
  output logic                     out_zrl,
  output logic                     out_eob,
  output logic [3:0]               out_run,
  output logic signed [COEF_W-1:0] out_level,
  output logic                     busy,
  output logic                     overrun,
  output logic [1:0]               dbg_state
);

  // Handshake: a symbol transfers on a cycle with out_valid & out_ready & ~hold;
  // out_valid and all symbol fields stay constant until that transfer.

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, FLUSH = 2'd2} state_t;

  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  state_t             state_q, state_d;
  logic [6:0]         k_q, k_d;
  logic               stg_vld_q, stg_vld_d;
  logic [5:0]         stg_k_q, stg_k_d;
  logic [4:0]         run_q, run_d;
  logic [1:0]         zrl_q, zrl_d;
  logic               pend_q, pend_d;
  logic               ovr_q, ovr_d;
  logic               need_eob_q, need_eob_d;
  logic               vld_q, vld_d;
  logic               dc_q, dc_d;
  logic               zsym_q, zsym_d;
  logic               eob_q, eob_d;
  logic [3:0]         srun_q, srun_d;
  logic [COEF_W-1:0]  lvl_q, lvl_d;

  logic               coef_nz, out_stall, zrl_blk, stall, rd_fire, eval, take, pend_after;
  logic               emit, e_dc, e_zrl, e_eob;
  logic [3:0]         e_run;
  logic [COEF_W-1:0]  e_lvl;

  assign coef_nz   = |coef_in;
  assign out_stall = vld_q & ~out_ready;
  assign zrl_blk   = stg_vld_q & coef_nz & (zrl_q != 2'd0);
  assign stall     = hold | out_stall | zrl_blk;
  assign rd_fire   = (state_q == READ) & ~stall & ~k_q[6];
  assign eval      = (state_q == READ) & stg_vld_q & ~hold & ~out_stall;

  assign rd_en     = rd_fire;
  assign rd_addr   = ZZ[k_q[5:0]];
  assign out_valid = vld_q;
  assign out_dc    = dc_q;
  assign out_zrl   = zsym_q;
  assign out_eob   = eob_q;
  assign out_run   = srun_q;
  assign out_level = lvl_q;
  assign busy      = (state_q != IDLE);
  assign overrun   = ovr_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    stg_vld_d  = stg_vld_q;
    stg_k_d    = stg_k_q;
    run_d      = run_q;
    zrl_d      = zrl_q;
    need_eob_d = need_eob_q;
    vld_d      = vld_q;
    dc_d       = dc_q;
    zsym_d     = zsym_q;
    eob_d      = eob_q;
    srun_d     = srun_q;
    lvl_d      = lvl_q;
    take       = 1'b0;
    emit       = 1'b0;
    e_dc       = 1'b0;
    e_zrl      = 1'b0;
    e_eob      = 1'b0;
    e_run      = 4'd0;
    e_lvl      = '0;
    if (!hold) begin
      if (vld_q && out_ready) vld_d = 1'b0;
      unique case (state_q)
        IDLE: if (dctq_valid || pend_q) take = 1'b1;
        READ: begin
          if (rd_fire) begin
            k_d       = k_q + 7'd1;
            stg_vld_d = 1'b1;
            stg_k_d   = k_q[5:0];
          end
          if (eval) begin
            if (zrl_blk) begin
              // Nonzero coefficient stays staged until the queued ZRLs are out.
              emit  = 1'b1;
              e_zrl = 1'b1;
              e_run = 4'd15;
              zrl_d = zrl_q - 2'd1;
            end else begin
              if (!rd_fire) stg_vld_d = 1'b0;
              if (stg_k_q == 6'd0) begin
                emit  = 1'b1;
                e_dc  = 1'b1;
                e_lvl = coef_in;
              end else if (!coef_nz) begin
                if (run_q == 5'd15) begin
                  run_d = 5'd0;
                  if (zrl_q != 2'd3) zrl_d = zrl_q + 2'd1;
                end else begin
                  run_d = run_q + 5'd1;
                end
              end else begin
                emit  = 1'b1;
                e_run = run_q[3:0];
                e_lvl = coef_in;
                run_d = 5'd0;
              end
              if (stg_k_q == 6'd63) begin
                state_d    = FLUSH;
                need_eob_d = ~coef_nz;
                zrl_d      = 2'd0;
              end
            end
          end
        end
        FLUSH: begin
          if (need_eob_q) begin
            if (!out_stall) begin
              emit       = 1'b1;
              e_eob      = 1'b1;
              need_eob_d = 1'b0;
            end
          end else if (!out_stall) begin
            // Last symbol is leaving; the next block may start reading now.
            if (pend_q) take = 1'b1;
            else        state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
      if (take) begin
        state_d   = READ;
        k_d       = 7'd0;
        run_d     = 5'd0;
        zrl_d     = 2'd0;
        stg_vld_d = 1'b0;
      end
      if (emit) begin
        vld_d  = 1'b1;
        dc_d   = e_dc;
        zsym_d = e_zrl;
        eob_d  = e_eob;
        srun_d = e_run;
        lvl_d  = e_lvl;
      end
    end
  end

  // Pulses are latched even under hold; a pulse arriving while one is queued is lost.
  always_comb begin
    pend_after = take ? 1'b0 : pend_q;
    pend_d     = pend_after;
    ovr_d      = ovr_q;
    if (dctq_valid && !((state_q == IDLE) && !hold && !pend_q)) begin
      if (pend_after) ovr_d  = 1'b1;
      else            pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      k_q        <= 7'd0;
      stg_vld_q  <= 1'b0;
      stg_k_q    <= 6'd0;
      run_q      <= 5'd0;
      zrl_q      <= 2'd0;
      pend_q     <= 1'b0;
      ovr_q      <= 1'b0;
      need_eob_q <= 1'b0;
      vld_q      <= 1'b0;
      dc_q       <= 1'b0;
      zsym_q     <= 1'b0;
      eob_q      <= 1'b0;
      srun_q     <= 4'd0;
      lvl_q      <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      stg_vld_q  <= stg_vld_d;
      stg_k_q    <= stg_k_d;
      run_q      <= run_d;
      zrl_q      <= zrl_d;
      pend_q     <= pend_d;
      ovr_q      <= ovr_d;
      need_eob_q <= need_eob_d;
      vld_q      <= vld_d;
      dc_q       <= dc_d;
      zsym_q     <= zsym_d;
      eob_q      <= eob_d;
      srun_q     <= srun_d;
      lvl_q      <= lvl_d;
    end
  end

endmodule
